// File: rtl/my_logic_acc.sv
// my_logic_acc
//   Registered bitwise logic unit with valid/ready handshakes on both sides.
//   Each accepted beat computes v = a op b (AND, OR, XOR, NAND). In per-beat
//   mode every beat produces one result. In accumulate mode a packet ending
//   at in_last is reduced to a single result, and the beat count saturates.
//
// Parameters
//   WIDTH  operand/result width (>=1)
//   CNT_W  width of out_count
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_a/in_b  operands
//   in_op      00 AND, 01 OR, 10 XOR, 11 NAND
//   in_acc     1 = accumulate packet, 0 = per-beat result
//   in_last    last beat of a packet (only meaningful when accumulating)
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_data   result
//   out_count  number of beats that contributed, saturating
//   out_parity ^out_data (only when MY_LOGIC_ACC_PARITY_EN is defined)
//
// Optional feature macro: MY_LOGIC_ACC_PARITY_EN
module my_logic_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef MY_LOGIC_ACC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;

  logic             accept;
  logic [1:0]       beat_op;
  logic [WIDTH-1:0] beat_val;
  logic [WIDTH-1:0] combined;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

  // Inside a packet the op latched on the first beat governs every beat,
  // so a NAND packet keeps contributing ~(a&b) even if in_op changes.
  assign beat_op = (state_reg == ACCUM) ? op_reg : in_op;

  always_comb begin
    beat_val = '0;
    case (beat_op)
      2'b00:   beat_val = in_a & in_b;
      2'b01:   beat_val = in_a | in_b;
      2'b10:   beat_val = in_a ^ in_b;
      default: beat_val = ~(in_a & in_b);
    endcase
  end

  // Packet reduction: AND and NAND packets both fold with AND.
  always_comb begin
    combined = '0;
    case (op_reg)
      2'b01:   combined = acc_reg | beat_val;
      2'b10:   combined = acc_reg ^ beat_val;
      default: combined = acc_reg & beat_val;
    endcase
  end

  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_data_next  = out_data_reg;
    out_count_next = out_count_reg;
    // Drain first; a load below in the same cycle overrides it.
    out_valid_next = out_valid_reg && !out_ready;

    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (in_acc && !in_last) begin
            op_next    = in_op;
            acc_next   = beat_val;
            cnt_next   = CNT_ONE;
            state_next = ACCUM;
          end else begin
            // Per-beat result, or a single-beat packet.
            out_data_next  = beat_val;
            out_count_next = CNT_ONE;
            out_valid_next = 1'b1;
          end
        end
        ACCUM: begin
          acc_next = combined;
          cnt_next = cnt_inc;
          if (in_last) begin
            out_data_next  = combined;
            out_count_next = cnt_inc;
            out_valid_next = 1'b1;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= 2'b00;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_count_reg <= out_count_next;
    end
  end

`ifdef MY_LOGIC_ACC_PARITY_EN
  // Registered alongside out_data so the two always change together.
  logic out_parity_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_parity_reg <= 1'b0;
    end else begin
      out_parity_reg <= ^out_data_next;
    end
  end

  assign out_parity = out_parity_reg;
`endif

endmodule

// File: tb/tb_my_logic_acc.sv
// Testbench for my_logic_acc: directed scenarios plus randomized traffic,
// checked against a packet-level reference model (beats collected in
// queues, reduced with plain arithmetic when the packet closes).
// Parity checks are compiled in when MY_LOGIC_ACC_PARITY_EN is defined.
module tb_my_logic_acc;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
`ifdef MY_LOGIC_ACC_PARITY_EN
  logic             out_parity;
`endif

  always #5 clk = ~clk;

  my_logic_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef MY_LOGIC_ACC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_count;
  bit               m_inpkt;
  logic [1:0]       m_op;
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];

  function automatic logic [WIDTH-1:0] beat_fn(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] reduce_pkt();
    logic [WIDTH-1:0] r;
    r = beat_fn(m_op, q_a[0], q_b[0]);
    for (int i = 1; i < q_a.size(); i++) begin
      case (m_op)
        2'd1:    r = r | beat_fn(m_op, q_a[i], q_b[i]);
        2'd2:    r = r ^ beat_fn(m_op, q_a[i], q_b[i]);
        default: r = r & beat_fn(m_op, q_a[i], q_b[i]);
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    m_valid = 0;
    m_data  = '0;
    m_count = 0;
    m_inpkt = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // Called one time unit after a rising edge: drive a beat, compare the DUT
  // against the model at the falling edge, advance the model, then cross
  // the next rising edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input bit acc, input bit last, input bit ordy);
    bit accept;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_acc    = acc;
    in_last   = last;
    out_ready = ordy;
    #4;
    check("out_valid", out_valid, m_valid);
    check("in_ready", in_ready, !m_valid || ordy);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_count", out_count, m_count);
`ifdef MY_LOGIC_ACC_PARITY_EN
      check("out_parity", out_parity, ^m_data);
`endif
    end
    accept = v && (!m_valid || ordy);
    if (m_valid && ordy) m_valid = 0;
    if (accept) begin
      if (!m_inpkt) begin
        m_op = op;
        q_a.delete();
        q_b.delete();
      end
      q_a.push_back(a);
      q_b.push_back(b);
      if (m_inpkt ? last : (!acc || last)) begin
        m_valid = 1;
        m_data  = reduce_pkt();
        m_count = (q_a.size() > CNT_SAT) ? CNT_SAT : q_a.size();
        m_inpkt = 0;
      end else begin
        m_inpkt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Literal check of the result just loaded (called right after step).
  task automatic peek(input string tag, input logic [WIDTH-1:0] d, input int c);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, out_count, c);
  endtask

  // Pulse reset between clock edges and confirm it acts without a clock.
  task automatic async_reset(input string tag);
    in_valid = 0;
    #2;
    reset = 1;
    #1;
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_ready"}, in_ready, 1'b1);
    #1;
    reset = 0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    in_valid = 0; in_a = '0; in_b = '0; in_op = 2'd0;
    in_acc = 0; in_last = 0; out_ready = 1;
    model_clear();
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    check("rst_ready", in_ready, 1'b1);
`ifdef MY_LOGIC_ACC_PARITY_EN
    check("rst_parity", out_parity, 1'b0);
`endif
    reset = 0;
    @(posedge clk);
    #1;

    // Per-beat ops
    step(1, 8'hF0, 8'h3C, 2'd0, 0, 0, 1); peek("and", 8'h30, 1);
    step(1, 8'hF0, 8'h3C, 2'd1, 0, 0, 1); peek("or", 8'hFC, 1);
    step(1, 8'hF0, 8'h3C, 2'd2, 0, 0, 1); peek("xor", 8'hCC, 1);
    step(1, 8'hF0, 8'h3C, 2'd3, 0, 0, 1); peek("nand", 8'hCF, 1);

    // XOR packet of three beats
    step(1, 8'h01, 8'h00, 2'd2, 1, 0, 1); check("xorpkt_b1_valid", out_valid, 1'b0);
    step(1, 8'h02, 8'h00, 2'd2, 1, 0, 1); check("xorpkt_b2_valid", out_valid, 1'b0);
    step(1, 8'h04, 8'h00, 2'd2, 1, 1, 1); peek("xorpkt", 8'h07, 3);
`ifdef MY_LOGIC_ACC_PARITY_EN
    check("parity_07", out_parity, 1'b1);
`endif
    step(1, 8'h0F, 8'h00, 2'd1, 0, 0, 1); peek("or0f", 8'h0F, 1);
`ifdef MY_LOGIC_ACC_PARITY_EN
    check("parity_0f", out_parity, 1'b0);
`endif

    // Backpressure: result held five cycles, then load with no bubble
    step(1, 8'hF0, 8'h3C, 2'd0, 0, 0, 1); peek("bp_first", 8'h30, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hAA, 8'h55, 2'd1, 0, 0, 0);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold_data", out_data, 8'h30);
    end
    step(1, 8'hAA, 8'h55, 2'd1, 0, 0, 1); peek("bp_next", 8'hFF, 1);

    // Op change mid-packet ignored; in_acc ignored on beat 2
    step(1, 8'hF0, 8'hFF, 2'd0, 1, 0, 1);
    step(1, 8'h3C, 8'hFF, 2'd1, 0, 1, 1); peek("opchg", 8'h30, 2);
    // NAND two-beat packet
    step(1, 8'hFF, 8'h0F, 2'd3, 1, 0, 1);
    step(1, 8'hFF, 8'hFF, 2'd3, 1, 1, 1); peek("nandpkt", 8'h00, 2);

    // Reset with a pending result, then reset mid-packet
    step(1, 8'h12, 8'h34, 2'd1, 0, 0, 0);
    async_reset("rst_out");
    step(1, 8'hFF, 8'h0F, 2'd0, 1, 0, 1);
    step(1, 8'hFF, 8'h0F, 2'd0, 1, 0, 1);
    async_reset("rst_acc");
    step(1, 8'h0A, 8'h50, 2'd1, 1, 1, 1); peek("after_rst", 8'h5A, 1);

    // 300-beat AND packet saturates the counter
    for (int i = 0; i < 299; i++)
      step(1, WIDTH'($urandom), WIDTH'($urandom), 2'd0, 1, 0, 1);
    step(1, 8'hFF, 8'hFF, 2'd0, 1, 1, 1);
    check("sat_count", out_count, CNT_SAT);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3) != 0), WIDTH'($urandom), WIDTH'($urandom),
           2'($urandom_range(3)), ($urandom_range(1) == 1),
           ($urandom_range(3) == 0), ($urandom_range(3) != 0));
    end
    step(0, '0, '0, 2'd0, 0, 0, 1);
    step(0, '0, '0, 2'd0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
